// File: rtl/auth_pkg.sv
// Shared definitions for the challenge/response authenticator:
// FSM state encoding, datapath width and the default shared secret.
package auth_pkg;

    localparam int WIDTH = 4;

    // Shared with the downstream authenticator so both ends agree on the secret
    localparam logic [WIDTH-1:0] DEFAULT_KEY = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LOCK = 2'd2
    } state_t;

endpackage

// File: rtl/auth_lfsr.sv
// 4-bit Fibonacci LFSR that supplies challenge values. It steps only when
// asked to, so the sequence position tracks accepted challenges.
module auth_lfsr
    import auth_pkg::*;
#(
    parameter logic [WIDTH-1:0] SEED = 4'b1001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    output logic [WIDTH-1:0] value
);

    // The all-zero state would lock the LFSR up, so a zero seed is replaced
    localparam logic [WIDTH-1:0] RESET_VALUE = (SEED == '0) ? WIDTH'(1) : SEED;

    // Shift left and feed back bit3^bit2, giving a maximal 15-state sequence
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= RESET_VALUE;
        end else if (advance) begin
            value <= {value[2:0], value[3] ^ value[2]};
        end
    end

endmodule

// File: rtl/auth_challenge_issuer.sv
// Issues an LFSR challenge, waits for a response or a timeout, reports
// success or failure, and locks out after repeated consecutive failures.
module auth_challenge_issuer
    import auth_pkg::*;
#(
    parameter logic [WIDTH-1:0] KEY         = DEFAULT_KEY,
    parameter logic [WIDTH-1:0] SEED        = 4'b1001,
    parameter int               TIMEOUT     = 8,
    parameter int               MAX_FAILS   = 3,
    parameter int               LOCK_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] response,
    output logic [WIDTH-1:0] challenge,
    output logic             chal_valid,
    output logic             authenticated,
    output logic             auth_fail,
    output logic             timeout,
    output logic             locked
);

    // Counters only need to reach their terminal value, which is N-1 (or N for fails)
    localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int LOCK_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);

    state_t               state;
    logic [TIMER_W-1:0]   timer;
    logic [LOCK_W-1:0]    lock_cnt;
    logic [FAIL_W-1:0]    fail_cnt;
    logic [FAIL_W-1:0]    fail_inc;
    logic [WIDTH-1:0]     lfsr_value;
    logic                 lfsr_advance;
    logic                 resp_ok;
    logic                 expired;

    // The LFSR steps exactly when a start is accepted, so an ignored start leaves it alone
    assign lfsr_advance = (state == IDLE) && start;
    assign resp_ok      = resp_valid && (response == (challenge ^ KEY));
    assign expired      = (timer == TIMER_W'(TIMEOUT - 1));
    assign fail_inc     = fail_cnt + FAIL_W'(1);

    auth_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (lfsr_advance),
        .value   (lfsr_value)
    );

    // Session FSM with timer, consecutive-failure count and lockout counter; all outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            timer         <= '0;
            lock_cnt      <= '0;
            fail_cnt      <= '0;
            challenge     <= '0;
            chal_valid    <= 1'b0;
            authenticated <= 1'b0;
            auth_fail     <= 1'b0;
            timeout       <= 1'b0;
            locked        <= 1'b0;
        end else begin
            auth_fail <= 1'b0;
            timeout   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        challenge     <= lfsr_value;
                        chal_valid    <= 1'b1;
                        timer         <= '0;
                        authenticated <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    timer <= timer + TIMER_W'(1);
                    // A response on the expiry cycle wins over the timeout
                    if (resp_valid || expired) begin
                        chal_valid <= 1'b0;
                        if (resp_ok) begin
                            authenticated <= 1'b1;
                            fail_cnt      <= '0;
                            state         <= IDLE;
                        end else begin
                            auth_fail <= 1'b1;
                            timeout   <= !resp_valid;
                            fail_cnt  <= fail_inc;
                            if (fail_inc == FAIL_W'(MAX_FAILS)) begin
                                locked   <= 1'b1;
                                lock_cnt <= '0;
                                state    <= LOCK;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                LOCK: begin
                    if (lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
                        locked   <= 1'b0;
                        fail_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        lock_cnt <= lock_cnt + LOCK_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
